// File: rtl/id_operand_unit.sv
// Decode-stage operand unit: 32x32 register file with write-through bypass,
// JAL link-data select, branch-compare forwarding and immediate sign extension.

module mux2 (
    input  logic        sel,
    input  logic [31:0] d0,
    input  logic [31:0] d1,
    output logic [31:0] y
);
    assign y = sel ? d1 : d0;
endmodule

module sign_ext (
    input  logic [15:0] a,
    output logic [31:0] y
);
    assign y = {{16{a[15]}}, a};
endmodule

module reg_file (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  a1,
    input  logic [4:0]  a2,
    input  logic [4:0]  a3,
    input  logic        we3,
    input  logic [31:0] wd3,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] regs [0:31];
    logic        wr_ok;

    // A write is live only outside reset and never targets r0
    assign wr_ok = we3 && !rst && (a3 != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[a3] <= wd3;
        end
    end

    always_comb begin
        rd1 = '0;
        if (a1 == 5'd0) begin
            rd1 = '0;
        end else if (wr_ok && (a3 == a1)) begin
            rd1 = wd3;
        end else begin
            rd1 = regs[a1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (a2 == 5'd0) begin
            rd2 = '0;
        end else if (wr_ok && (a3 == a2)) begin
            rd2 = wd3;
        end else begin
            rd2 = regs[a2];
        end
    end
endmodule

module id_operand_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        print_en,
    input  logic [4:0]  a1,
    input  logic [4:0]  a2,
    input  logic [4:0]  a3,
    input  logic        we3,
    input  logic [31:0] result_w,
    input  logic [31:0] pc_plus4_d,
    input  logic        jal,
    input  logic [31:0] alu_out_m,
    input  logic        forward_ad,
    input  logic        forward_bd,
    input  logic [15:0] imm16,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] rd1_d,
    output logic [31:0] rd2_d,
    output logic [31:0] sign_imm,
    output logic [31:0] wd3
);
    // Register dump is a simulation-side concern; no hardware hangs off it
    logic unused_print_en;
    assign unused_print_en = print_en;

    mux2 u_wd_mux (
        .sel (jal),
        .d0  (result_w),
        .d1  (pc_plus4_d),
        .y   (wd3)
    );

    reg_file u_rf (
        .clk (clk),
        .rst (rst),
        .a1  (a1),
        .a2  (a2),
        .a3  (a3),
        .we3 (we3),
        .wd3 (wd3),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    mux2 u_fwd_a (
        .sel (forward_ad),
        .d0  (rd1),
        .d1  (alu_out_m),
        .y   (rd1_d)
    );

    mux2 u_fwd_b (
        .sel (forward_bd),
        .d0  (rd2),
        .d1  (alu_out_m),
        .y   (rd2_d)
    );

    sign_ext u_se (
        .a (imm16),
        .y (sign_imm)
    );
endmodule

// File: tb/tb_id_operand_unit.sv
// Directed self-checking bench for id_operand_unit.
// Expected values are hand-computed constants.

module tb_id_operand_unit;
    logic        clk;
    logic        rst;
    logic        print_en;
    logic [4:0]  a1, a2, a3;
    logic        we3;
    logic [31:0] result_w, pc_plus4_d, alu_out_m;
    logic        jal, forward_ad, forward_bd;
    logic [15:0] imm16;
    logic [31:0] rd1, rd2, rd1_d, rd2_d, sign_imm, wd3;

    int n_run;
    int n_fail;

    id_operand_unit dut (
        .clk        (clk),
        .rst        (rst),
        .print_en   (print_en),
        .a1         (a1),
        .a2         (a2),
        .a3         (a3),
        .we3        (we3),
        .result_w   (result_w),
        .pc_plus4_d (pc_plus4_d),
        .jal        (jal),
        .alu_out_m  (alu_out_m),
        .forward_ad (forward_ad),
        .forward_bd (forward_bd),
        .imm16      (imm16),
        .rd1        (rd1),
        .rd2        (rd2),
        .rd1_d      (rd1_d),
        .rd2_d      (rd2_d),
        .sign_imm   (sign_imm),
        .wd3        (wd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        a3 = addr;
        result_w = data;
        jal = 1'b0;
        we3 = 1'b1;
        tick();
        we3 = 1'b0;
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        rst = 1'b1;
        print_en = 1'b0;
        a1 = '0; a2 = '0; a3 = '0;
        we3 = 1'b0;
        result_w = '0;
        pc_plus4_d = '0;
        alu_out_m = '0;
        jal = 1'b0;
        forward_ad = 1'b0;
        forward_bd = 1'b0;
        imm16 = '0;
        #2;

        // all addresses read zero in reset, write port and bypass ignored
        we3 = 1'b1;
        a3 = 5'd5;
        result_w = 32'h1111_2222;
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i);
            a2 = 5'(31 - i);
            #1;
            chk($sformatf("rst_rd1_r%0d", i), rd1, 32'h0);
            chk($sformatf("rst_rd2_r%0d", 31 - i), rd2, 32'h0);
        end
        tick();
        a1 = 5'd5;
        #1;
        chk("rst_write_ignored", rd1, 32'h0);
        alu_out_m = 32'h0000_0abc;
        forward_ad = 1'b1;
        #1;
        chk("rst_fwd_rd1_d", rd1_d, 32'h0000_0abc);
        chk("rst_nofwd_rd2_d", rd2_d, 32'h0);
        chk("rst_wd3", wd3, 32'h1111_2222);
        forward_ad = 1'b0;
        we3 = 1'b0;

        @(negedge clk);
        rst = 1'b0;

        wr(5'd5, 32'hDEAD_BEEF);
        a1 = 5'd5;
        #1;
        chk("r5_write", rd1, 32'hDEAD_BEEF);

        // r0 protection, including no bypass
        a3 = 5'd0;
        result_w = 32'h1234_5678;
        we3 = 1'b1;
        a1 = 5'd0;
        a2 = 5'd0;
        #1;
        chk("r0_nobypass_rd1", rd1, 32'h0);
        chk("r0_nobypass_rd2", rd2, 32'h0);
        tick();
        we3 = 1'b0;
        #1;
        chk("r0_after", rd1, 32'h0);

        // write-through bypass
        a3 = 5'd9;
        result_w = 32'hA5A5_A5A5;
        we3 = 1'b1;
        a1 = 5'd9;
        a2 = 5'd9;
        #1;
        chk("bypass_rd1", rd1, 32'hA5A5_A5A5);
        chk("bypass_rd2", rd2, 32'hA5A5_A5A5);
        tick();
        we3 = 1'b0;
        result_w = 32'h0;
        #1;
        chk("stored_rd1", rd1, 32'hA5A5_A5A5);
        chk("stored_rd2", rd2, 32'hA5A5_A5A5);

        // JAL link
        jal = 1'b1;
        pc_plus4_d = 32'h0000_0048;
        result_w = 32'hFFFF_FFFF;
        a3 = 5'd31;
        we3 = 1'b1;
        #1;
        chk("jal_wd3", wd3, 32'h0000_0048);
        tick();
        we3 = 1'b0;
        jal = 1'b0;
        a1 = 5'd31;
        #1;
        chk("jal_r31", rd1, 32'h0000_0048);
        chk("wd3_nojal", wd3, 32'hFFFF_FFFF);

        // forwarding
        wr(5'd3, 32'h7);
        alu_out_m = 32'h100;
        forward_ad = 1'b1;
        forward_bd = 1'b0;
        a1 = 5'd3;
        a2 = 5'd3;
        #1;
        chk("fwd_rd1_d", rd1_d, 32'h100);
        chk("fwd_rd2_d", rd2_d, 32'h7);
        chk("fwd_rd1", rd1, 32'h7);

        // forwarding beats bypass
        forward_ad = 1'b0;
        forward_bd = 1'b1;
        a3 = 5'd3;
        result_w = 32'h55;
        we3 = 1'b1;
        #1;
        chk("bypass_rd1_d", rd1_d, 32'h55);
        chk("fwdpri_rd2_d", rd2_d, 32'h100);
        we3 = 1'b0;
        forward_bd = 1'b0;

        // sign extension
        imm16 = 16'hFFFC;
        #1;
        chk("sext_fffc", sign_imm, 32'hFFFF_FFFC);
        imm16 = 16'h0004;
        #1;
        chk("sext_0004", sign_imm, 32'h0000_0004);
        imm16 = 16'h8000;
        #1;
        chk("sext_8000", sign_imm, 32'hFFFF_8000);
        imm16 = 16'h7FFF;
        #1;
        chk("sext_7fff", sign_imm, 32'h0000_7FFF);

        // async reset clears, reset beats simultaneous write
        print_en = 1'b1;
        a1 = 5'd31;
        a2 = 5'd5;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_rst_r31", rd1, 32'h0);
        chk("async_rst_r5", rd2, 32'h0);
        a3 = 5'd5;
        result_w = 32'hCAFE_F00D;
        we3 = 1'b1;
        tick();
        we3 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_beats_write", rd2, 32'h0);
        print_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
